box_plot_engine: RTL and testbench
==================================

Name: box_plot_engine

Overview:
Parametrised rectangle rasteriser for the VGA plotting path. It latches an origin, a box size, a colour and a mode on a start pulse. It then walks every pixel of the box in raster order, emitting one (x, y, colour) plot request per cycle into the VGA adapter. It adds variable box size, a draw/erase mode, screen-edge clipping and plot back-pressure, which a fixed 4x4 offset adder does not have.

Parameters:
X_W, 8, width of x coordinate buses
Y_W, 7, width of y coordinate buses
SIZE_W, 3, width of box size fields; max box is 2^SIZE_W x 2^SIZE_W
COLOR_W, 3, width of colour buses
X_MAX, 160, screen width; pixels with x >= X_MAX are clipped
Y_MAX, 120, screen height; pixels with y >= Y_MAX are clipped
BG_COLOR, 0, colour used in erase mode

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request a box; sampled only in IDLE
xpos  in  X_W  box origin x (top-left)
ypos  in  Y_W  box origin y (top-left)
w_m1  in  SIZE_W  box width minus 1
h_m1  in  SIZE_W  box height minus 1
colour_in  in  COLOR_W  fill colour in draw mode
erase  in  1  1 = fill with BG_COLOR; 0 = fill with colour_in
plot_ready  in  1  VGA side accepts the current pixel this cycle
x_out  out  X_W  pixel x
y_out  out  Y_W  pixel y
colour_out  out  COLOR_W  pixel colour
plot  out  1  pixel valid (plot request)
busy  out  1  high while in DRAW
done  out  1  one-cycle pulse after the last pixel is retired

Behaviour:
- Reset is asynchronous and active-low. While resetn=0: state=IDLE; all latched and counter registers are 0; x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0. Reset asserted mid-DRAW aborts the box immediately, and no done pulse is generated.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - On start=1 at an edge, latch x0=xpos, y0=ypos, wm=w_m1, hm=h_m1, col=(erase ? BG_COLOR : colour_in).
  - Clear counters cx=0, cy=0 and go to DRAW.
  - start=0: remain in IDLE.
- DRAW:
  - busy=1.
  - Current pixel: xs=x0+cx and ys=y0+cy, computed at X_W+1 and Y_W+1 bits with no wrap.
  - in_bounds = (xs < X_MAX) && (ys < Y_MAX).
  - Outputs are driven combinationally from registers: x_out=xs[X_W-1:0], y_out=ys[Y_W-1:0], colour_out=col, plot=in_bounds.
  - Retire the pixel when (in_bounds && plot_ready) || !in_bounds. A clipped pixel retires in one cycle regardless of plot_ready.
  - On retire, advance in raster order, cx fastest: if cx==wm then cx=0 and cy=cy+1, else cx=cx+1.
  - If the retired pixel is cx==wm && cy==hm, go to DONE instead of advancing.
  - Not retired (plot=1, plot_ready=0): cx, cy and all outputs hold.
- DONE: done=1 for exactly one cycle, plot=0, busy=0; go to IDLE unconditionally.
- start is ignored in DRAW and DONE; no queuing.
- Outside DRAW, plot=0. x_out, y_out and colour_out hold their last values; they are don't-care to the consumer.
- Latency with no stalls: start sampled at edge N. First pixel is valid in cycle N+1. The last pixel is in cycle N+(wm+1)(hm+1). done is high in the following cycle. The next start is accepted one cycle after done.
- Widths: w_m1 and h_m1 cover sizes 1..2^SIZE_W; a 1x1 box (0,0) is legal. Origin alone out of bounds clips the entire box, but the walk and the done pulse still occur.

Test Plan:
- Reset, then start with xpos=10, ypos=20, w_m1=3, h_m1=3, colour_in=5, erase=0, plot_ready=1 -> 16 plot cycles in order (10,20),(11,20)…(13,20),(10,21)…(13,23), all colour 5; done exactly one cycle after the 16th pixel; busy high for exactly 16 cycles.
- xpos=158, ypos=118, 4x4 box -> plot=1 only for (158,118),(159,118),(158,119),(159,119); still 16 DRAW cycles, then done.
- 4x4 box with plot_ready held 0 for 3 cycles at pixel (11,20) -> x_out, y_out and plot hold for those cycles; the pixel sequence is unchanged; done is delayed by 3 cycles.
- erase=1, colour_in=6, w_m1=0, h_m1=1 -> two plots (xpos,ypos) and (xpos,ypos+1) with colour_out=BG_COLOR (0).
- Pulse start again during DRAW with different origin -> ignored; the current box completes unchanged and exactly one done pulse occurs.
- Assert resetn=0 asynchronously mid-box (between clock edges) -> plot, busy and done drop to 0 immediately with no done pulse; a new start after release draws the new box from cx=cy=0.

Source files
------------

// File: rtl/box_plot_engine.sv
// Rectangle rasteriser: latches a box request and walks its pixels in raster
// order, emitting one clipped plot request per cycle with back-pressure.
module box_plot_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 3,
  parameter int COLOR_W  = 3,
  parameter int X_MAX    = 160,
  parameter int Y_MAX    = 120,
  parameter int BG_COLOR = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     xpos,
  input  logic [Y_W-1:0]     ypos,
  input  logic [SIZE_W-1:0]  w_m1,
  input  logic [SIZE_W-1:0]  h_m1,
  input  logic [COLOR_W-1:0] colour_in,
  input  logic               erase,
  input  logic               plot_ready,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] colour_out,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [X_W:0]        X_LIM   = X_MAX[X_W:0];
  localparam logic [Y_W:0]        Y_LIM   = Y_MAX[Y_W:0];
  localparam logic [COLOR_W-1:0]  BG_COL  = BG_COLOR[COLOR_W-1:0];
  localparam logic [SIZE_W-1:0]   SZ_ONE  = {{(SIZE_W-1){1'b0}}, 1'b1};
  localparam logic [SIZE_W-1:0]   SZ_ZERO = {SIZE_W{1'b0}};

  state_t              state_r, state_s;
  logic [X_W-1:0]      x0_r, x0_s;
  logic [Y_W-1:0]      y0_r, y0_s;
  logic [SIZE_W-1:0]   wm_r, wm_s;
  logic [SIZE_W-1:0]   hm_r, hm_s;
  logic [SIZE_W-1:0]   cx_r, cx_s;
  logic [SIZE_W-1:0]   cy_r, cy_s;
  logic [COLOR_W-1:0]  col_r, col_s;

  logic [X_W:0]        xs_s;
  logic [Y_W:0]        ys_s;
  logic                in_bounds_s;
  logic                retire_s;

  // One extra bit keeps far-edge pixels from wrapping back on screen.
  assign xs_s        = {1'b0, x0_r} + {{(X_W+1-SIZE_W){1'b0}}, cx_r};
  assign ys_s        = {1'b0, y0_r} + {{(Y_W+1-SIZE_W){1'b0}}, cy_r};
  assign in_bounds_s = (xs_s < X_LIM) && (ys_s < Y_LIM);
  assign retire_s    = !in_bounds_s || plot_ready;

  assign x_out      = xs_s[X_W-1:0];
  assign y_out      = ys_s[Y_W-1:0];
  assign colour_out = col_r;
  assign plot       = (state_r == ST_DRAW) && in_bounds_s;
  assign busy       = (state_r == ST_DRAW);
  assign done       = (state_r == ST_DONE);

  // Next-state, request latch and raster counter advance.
  always_comb begin
    state_s = state_r;
    x0_s    = x0_r;
    y0_s    = y0_r;
    wm_s    = wm_r;
    hm_s    = hm_r;
    cx_s    = cx_r;
    cy_s    = cy_r;
    col_s   = col_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          x0_s    = xpos;
          y0_s    = ypos;
          wm_s    = w_m1;
          hm_s    = h_m1;
          col_s   = erase ? BG_COL : colour_in;
          cx_s    = SZ_ZERO;
          cy_s    = SZ_ZERO;
          state_s = ST_DRAW;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (retire_s) begin
          // Counters stay on the last pixel so the outputs hold after the box.
          if ((cx_r == wm_r) && (cy_r == hm_r)) begin
            state_s = ST_DONE;
          end else if (cx_r == wm_r) begin
            cx_s = SZ_ZERO;
            cy_s = cy_r + SZ_ONE;
          end else begin
            cx_s = cx_r + SZ_ONE;
          end
        end else begin
          state_s = ST_DRAW;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      x0_r    <= {X_W{1'b0}};
      y0_r    <= {Y_W{1'b0}};
      wm_r    <= SZ_ZERO;
      hm_r    <= SZ_ZERO;
      cx_r    <= SZ_ZERO;
      cy_r    <= SZ_ZERO;
      col_r   <= {COLOR_W{1'b0}};
    end else begin
      state_r <= state_s;
      x0_r    <= x0_s;
      y0_r    <= y0_s;
      wm_r    <= wm_s;
      hm_r    <= hm_s;
      cx_r    <= cx_s;
      cy_r    <= cy_s;
      col_r   <= col_s;
    end
  end

endmodule

// File: tb/tb_box_plot_engine.sv
// Directed and randomised boxes checked against a pixel-list reference model.
module tb_box_plot_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] xpos;
  logic [6:0] ypos;
  logic [2:0] w_m1, h_m1;
  logic [2:0] colour_in;
  logic       erase;
  logic       plot_ready;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  int ex_x[$];
  int ex_y[$];
  bit ex_p[$];

  always #5 clk = ~clk;

  box_plot_engine dut (
    .clk(clk), .resetn(resetn), .start(start), .xpos(xpos), .ypos(ypos),
    .w_m1(w_m1), .h_m1(h_m1), .colour_in(colour_in), .erase(erase),
    .plot_ready(plot_ready), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list every pixel of the box in raster order, with its clip flag.
  task automatic build(input int xp, input int yp, input int w, input int h);
    int xs, ys;
    ex_x.delete(); ex_y.delete(); ex_p.delete();
    for (int yy = 0; yy <= h; yy++) begin
      for (int xx = 0; xx <= w; xx++) begin
        xs = xp + xx;
        ys = yp + yy;
        ex_x.push_back(xs % 256);
        ex_y.push_back(ys % 128);
        ex_p.push_back((xs < 160) && (ys < 120));
      end
    end
  endtask

  // rmode: 0 always ready, 1 random ready, 2 three-cycle stall at pixel stall_at.
  task automatic run_box(input int xp, input int yp, input int w, input int h,
                         input int col, input int er, input int rmode,
                         input int stall_at, input bit start_mid);
    int idx, cyc, stalls, ecol;
    build(xp, yp, w, h);
    ecol = (er != 0) ? 0 : col;
    @(negedge clk);
    xpos = 8'(xp); ypos = 7'(yp); w_m1 = 3'(w); h_m1 = 3'(h);
    colour_in = 3'(col); erase = (er != 0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; stalls = 0;
    while (idx < ex_x.size() && cyc < 500) begin
      chk("busy", 32'(busy), 32'd1);
      chk("done_in_draw", 32'(done), 32'd0);
      chk("plot", 32'(plot), 32'(ex_p[idx]));
      chk("x_out", 32'(x_out), 32'(ex_x[idx]));
      chk("y_out", 32'(y_out), 32'(ex_y[idx]));
      chk("colour", 32'(colour_out), 32'(ecol));
      case (rmode)
        0: plot_ready = 1'b1;
        1: plot_ready = ($urandom_range(0, 3) != 0);
        default: begin
          plot_ready = !((idx == stall_at) && (stalls < 3));
          if (!plot_ready) stalls++;
        end
      endcase
      if (start_mid && cyc == 2) begin
        start = 1'b1; xpos = 8'(xp + 40); ypos = 7'(yp + 9); w_m1 = 3'd0; h_m1 = 3'd0;
      end else begin
        start = 1'b0;
      end
      if (!ex_p[idx] || plot_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    plot_ready = 1'b1;
    chk("walk_timeout", 32'(idx), 32'(ex_x.size()));
    if (rmode == 2) chk("stall_cycles", 32'(cyc), 32'(ex_x.size() + 3));
    else if (rmode == 0) chk("draw_cycles", 32'(cyc), 32'(ex_x.size()));
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("plot_done", 32'(plot), 32'd0);
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("plot_idle", 32'(plot), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; xpos = 8'd0; ypos = 7'd0; w_m1 = 3'd0; h_m1 = 3'd0;
    colour_in = 3'd0; erase = 1'b0; plot_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_col", 32'(colour_out), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    run_box(10, 20, 3, 3, 5, 0, 0, 0, 1'b0);
    run_box(158, 118, 3, 3, 2, 0, 0, 0, 1'b0);
    run_box(10, 20, 3, 3, 3, 0, 2, 1, 1'b0);
    run_box(50, 60, 0, 1, 6, 1, 0, 0, 1'b0);
    run_box(30, 40, 3, 3, 7, 0, 0, 0, 1'b1);
    run_box(0, 0, 0, 0, 4, 0, 0, 0, 1'b0);
    run_box(200, 10, 1, 1, 1, 0, 0, 0, 1'b0);
    run_box(252, 124, 7, 7, 5, 0, 1, 0, 1'b0);

    // Asynchronous reset in the middle of a box.
    @(negedge clk);
    xpos = 8'd10; ypos = 7'd20; w_m1 = 3'd3; h_m1 = 3'd3; colour_in = 3'd5;
    erase = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_plot", 32'(plot), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_x", 32'(x_out), 32'd0);
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    run_box(30, 40, 2, 1, 3, 0, 0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_box($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), 1, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
